// File: rtl/adma_desc_queue_if.sv
// Descriptor push/issue bus between the register map, the descriptor queue and the engine.
// The slave modport is the queue side; the master modport is the register map / engine side.
interface adma_desc_queue_if #(
  parameter int unsigned DMA_LENGTH_W  = 16,
  parameter int unsigned SRC_ADDR_W    = 32,
  parameter int unsigned DST_ADDR_W    = 32,
  parameter int unsigned DMA_XFER_ID_W = 2
);
  logic                     desc_wr_vld_i;
  logic                     desc_wr_rdy_o;
  logic [SRC_ADDR_W-1:0]    desc_src_addr_i;
  logic [DST_ADDR_W-1:0]    desc_dst_addr_i;
  logic [DMA_LENGTH_W-1:0]  desc_xlen_i;
  logic [DMA_LENGTH_W-1:0]  desc_ylen_i;
  logic [DMA_LENGTH_W-1:0]  desc_src_strd_i;
  logic [DMA_LENGTH_W-1:0]  desc_dst_strd_i;

  logic                     desc_rd_vld_o;
  logic                     desc_rd_rdy_i;
  logic [SRC_ADDR_W-1:0]    desc_src_addr_o;
  logic [DST_ADDR_W-1:0]    desc_dst_addr_o;
  logic [DMA_LENGTH_W-1:0]  desc_xlen_o;
  logic [DMA_LENGTH_W-1:0]  desc_ylen_o;
  logic [DMA_LENGTH_W-1:0]  desc_src_strd_o;
  logic [DMA_LENGTH_W-1:0]  desc_dst_strd_o;
  logic [DMA_XFER_ID_W-1:0] desc_rd_id_o;

  modport slave (
    input  desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xlen_i, desc_ylen_i,
           desc_src_strd_i, desc_dst_strd_i, desc_rd_rdy_i,
    output desc_wr_rdy_o, desc_rd_vld_o, desc_src_addr_o, desc_dst_addr_o, desc_xlen_o,
           desc_ylen_o, desc_src_strd_o, desc_dst_strd_o, desc_rd_id_o
  );

  modport master (
    output desc_wr_vld_i, desc_src_addr_i, desc_dst_addr_i, desc_xlen_i, desc_ylen_i,
           desc_src_strd_i, desc_dst_strd_i, desc_rd_rdy_i,
    input  desc_wr_rdy_o, desc_rd_vld_o, desc_src_addr_o, desc_dst_addr_o, desc_xlen_o,
           desc_ylen_o, desc_src_strd_o, desc_dst_strd_o, desc_rd_id_o
  );
endinterface

// File: rtl/adma_desc_queue.sv
// Per-channel DMA descriptor FIFO: accepts pushes, issues one descriptor at a time to the
// engine, tracks the active transfer length, per-slot done flags and sticky IRQ sources.
module adma_desc_queue #(
  parameter  int unsigned DMA_DESC_DEPTH = 4,
  parameter  int unsigned DMA_LENGTH_W   = 16,
  parameter  int unsigned SRC_ADDR_W     = 32,
  parameter  int unsigned DST_ADDR_W     = 32,
  localparam int unsigned DMA_XFER_ID_W  = $clog2(DMA_DESC_DEPTH)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      chn_en_i,
  input  logic                      irq_msk_com_i,
  input  logic                      irq_msk_qed_i,
  input  logic [1:0]                irq_clr_i,
  adma_desc_queue_if.slave          desc,
  input  logic                      xfer_prog_i,
  input  logic                      xfer_cmpl_i,
  output logic [DMA_XFER_ID_W-1:0]  xfer_id_o,
  output logic [DMA_DESC_DEPTH-1:0] xfer_done_o,
  output logic [DMA_XFER_ID_W-1:0]  active_xfer_id_o,
  output logic [DMA_LENGTH_W-1:0]   active_xfer_len_o,
  output logic                      irq_com_o,
  output logic                      irq_qed_o
);

  localparam int unsigned ID_W  = DMA_XFER_ID_W;
  localparam int unsigned PTR_W = ID_W + 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t state, state_n;

  logic [PTR_W-1:0] wr_ptr, rd_ptr, cmpl_ptr;
  logic [PTR_W-1:0] cnt;
  logic [ID_W-1:0]  wr_slot, rd_slot;
  logic             push, issue, cmpl_fire, prog_fire;

  logic [SRC_ADDR_W-1:0]   mem_src_addr [DMA_DESC_DEPTH];
  logic [DST_ADDR_W-1:0]   mem_dst_addr [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] mem_xlen     [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] mem_ylen     [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] mem_src_strd [DMA_DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] mem_dst_strd [DMA_DESC_DEPTH];

  // Occupancy counts until completion, so an issued slot stays reserved while it runs.
  assign cnt     = wr_ptr - cmpl_ptr;
  assign wr_slot = wr_ptr[ID_W-1:0];
  assign rd_slot = rd_ptr[ID_W-1:0];

  assign desc.desc_wr_rdy_o = (cnt != PTR_W'(DMA_DESC_DEPTH));
  assign desc.desc_rd_vld_o = chn_en_i && (state == ST_IDLE) && (rd_ptr != wr_ptr);

  assign push      = desc.desc_wr_vld_i && desc.desc_wr_rdy_o;
  assign issue     = desc.desc_rd_vld_o && desc.desc_rd_rdy_i;
  assign cmpl_fire = (state == ST_ACTIVE) && xfer_cmpl_i;
  assign prog_fire = (state == ST_ACTIVE) && xfer_prog_i && !xfer_cmpl_i;

  assign desc.desc_src_addr_o = mem_src_addr[rd_slot];
  assign desc.desc_dst_addr_o = mem_dst_addr[rd_slot];
  assign desc.desc_xlen_o     = mem_xlen[rd_slot];
  assign desc.desc_ylen_o     = mem_ylen[rd_slot];
  assign desc.desc_src_strd_o = mem_src_strd[rd_slot];
  assign desc.desc_dst_strd_o = mem_dst_strd[rd_slot];
  assign desc.desc_rd_id_o    = rd_slot;

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next-state: at most one transfer in flight
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (issue)       state_n = ST_ACTIVE;
      ST_ACTIVE: if (xfer_cmpl_i) state_n = ST_IDLE;
      default:                    state_n = ST_IDLE;
    endcase
  end

  // Descriptor storage
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(DMA_DESC_DEPTH); i++) begin
        mem_src_addr[i] <= '0;
        mem_dst_addr[i] <= '0;
        mem_xlen[i]     <= '0;
        mem_ylen[i]     <= '0;
        mem_src_strd[i] <= '0;
        mem_dst_strd[i] <= '0;
      end
    end else if (push) begin
      mem_src_addr[wr_slot] <= desc.desc_src_addr_i;
      mem_dst_addr[wr_slot] <= desc.desc_dst_addr_i;
      mem_xlen[wr_slot]     <= desc.desc_xlen_i;
      mem_ylen[wr_slot]     <= desc.desc_ylen_i;
      mem_src_strd[wr_slot] <= desc.desc_src_strd_i;
      mem_dst_strd[wr_slot] <= desc.desc_dst_strd_i;
    end
  end

  // Pointers, transfer tracking and done flags
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      cmpl_ptr          <= '0;
      xfer_id_o         <= '0;
      xfer_done_o       <= '0;
      active_xfer_id_o  <= '0;
      active_xfer_len_o <= '0;
    end else begin
      if (push) begin
        wr_ptr               <= wr_ptr + PTR_W'(1);
        xfer_id_o            <= wr_slot;
        xfer_done_o[wr_slot] <= 1'b0;
      end
      if (issue) begin
        rd_ptr            <= rd_ptr + PTR_W'(1);
        active_xfer_id_o  <= rd_slot;
        active_xfer_len_o <= desc.desc_xlen_o;
      end
      // A pushed slot is never the active one, so these done-bit writes never collide.
      if (cmpl_fire) begin
        cmpl_ptr                      <= cmpl_ptr + PTR_W'(1);
        xfer_done_o[active_xfer_id_o] <= 1'b1;
        active_xfer_len_o             <= '0;
      end else if (prog_fire && (active_xfer_len_o != '0)) begin
        active_xfer_len_o <= active_xfer_len_o - DMA_LENGTH_W'(1);
      end
    end
  end

  // Sticky IRQ sources: set beats clear
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_com_o <= 1'b0;
      irq_qed_o <= 1'b0;
    end else begin
      if (cmpl_fire && irq_msk_com_i) irq_com_o <= 1'b1;
      else if (irq_clr_i[0])          irq_com_o <= 1'b0;
      if (push && irq_msk_qed_i)      irq_qed_o <= 1'b1;
      else if (irq_clr_i[1])          irq_qed_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adma_desc_queue.sv
// Self-checking bench for adma_desc_queue: directed scenarios plus randomized traffic
// checked against a transaction-level queue model.
module tb_adma_desc_queue;
  localparam int unsigned D   = 4;
  localparam int unsigned LW  = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned IDW = 2;

  typedef struct {
    logic [AW-1:0] src, dst;
    logic [LW-1:0] xlen, ylen, sstr, dstr;
    int            id;
  } m_desc_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic chn_en = 1'b0, msk_com = 1'b0, msk_qed = 1'b0;
  logic [1:0] irq_clr = 2'b00;
  logic xfer_prog = 1'b0, xfer_cmpl = 1'b0;
  logic [IDW-1:0] xfer_id, active_id;
  logic [D-1:0]   xfer_done;
  logic [LW-1:0]  active_len;
  logic irq_com, irq_qed;

  adma_desc_queue_if #(.DMA_LENGTH_W(LW), .SRC_ADDR_W(AW), .DST_ADDR_W(AW),
                       .DMA_XFER_ID_W(IDW)) dif ();

  adma_desc_queue #(.DMA_DESC_DEPTH(D), .DMA_LENGTH_W(LW), .SRC_ADDR_W(AW),
                    .DST_ADDR_W(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .chn_en_i(chn_en), .irq_msk_com_i(msk_com),
    .irq_msk_qed_i(msk_qed), .irq_clr_i(irq_clr), .desc(dif), .xfer_prog_i(xfer_prog),
    .xfer_cmpl_i(xfer_cmpl), .xfer_id_o(xfer_id), .xfer_done_o(xfer_done),
    .active_xfer_id_o(active_id), .active_xfer_len_o(active_len),
    .irq_com_o(irq_com), .irq_qed_o(irq_qed)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: list of unfinished descriptors; head is the active one when m_active.
  m_desc_t  m_q[$];
  bit       m_active;
  int       m_next_id, m_xfer_id, m_act_id;
  int       m_len;
  bit [D-1:0] m_done;
  bit       m_irq_com, m_irq_qed;

  task automatic model_reset();
    m_q.delete();
    m_active = 0; m_next_id = 0; m_xfer_id = 0; m_act_id = 0; m_len = 0;
    m_done = '0; m_irq_com = 0; m_irq_qed = 0;
  endtask

  task automatic drive_idle();
    dif.desc_wr_vld_i = 0; dif.desc_rd_rdy_i = 0;
    xfer_prog = 0; xfer_cmpl = 0; irq_clr = 2'b00;
  endtask

  task automatic rand_payload(input int xlen);
    dif.desc_src_addr_i = $urandom; dif.desc_dst_addr_i = $urandom;
    dif.desc_xlen_i = (xlen < 0) ? LW'($urandom_range(0, 12)) : LW'(xlen);
    dif.desc_ylen_i = LW'($urandom); dif.desc_src_strd_i = LW'($urandom);
    dif.desc_dst_strd_i = LW'($urandom);
  endtask

  // Advance one clock: decide what fires from the model's own rules, then update it.
  task automatic tick();
    bit push_f, issue_f, cmpl_f, prog_f, rst;
    m_desc_t e;
    rst     = !aresetn;
    push_f  = dif.desc_wr_vld_i && (m_q.size() < int'(D));
    issue_f = chn_en && !m_active && (m_q.size() > 0) && dif.desc_rd_rdy_i;
    cmpl_f  = m_active && xfer_cmpl;
    prog_f  = m_active && xfer_prog && !xfer_cmpl;
    e.src = dif.desc_src_addr_i; e.dst = dif.desc_dst_addr_i; e.xlen = dif.desc_xlen_i;
    e.ylen = dif.desc_ylen_i; e.sstr = dif.desc_src_strd_i; e.dstr = dif.desc_dst_strd_i;
    e.id = m_next_id;
    @(posedge aclk);
    if (rst) begin
      model_reset();
    end else begin
      if (cmpl_f) begin
        m_done[m_q[0].id] = 1; void'(m_q.pop_front()); m_active = 0; m_len = 0;
        if (msk_com) m_irq_com = 1;
        else if (irq_clr[0]) m_irq_com = 0;
      end else begin
        if (prog_f && m_len > 0) m_len--;
        if (irq_clr[0]) m_irq_com = 0;
      end
      if (issue_f) begin
        m_active = 1; m_act_id = m_q[0].id; m_len = int'(m_q[0].xlen);
      end
      if (push_f) begin
        m_q.push_back(e); m_done[e.id] = 0; m_xfer_id = e.id;
        m_next_id = (m_next_id + 1) % int'(D);
      end
      if (push_f && msk_qed) m_irq_qed = 1;
      else if (irq_clr[1]) m_irq_qed = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive_idle(); aresetn = 0; tick(); tick(); aresetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({xfer_id, active_id, active_len, xfer_done, irq_com, irq_qed} !== '0) begin
      failures++; $display("FAIL reset_regs got id=%0d act=%0d len=%0d done=%b com=%b qed=%b want all 0",
        xfer_id, active_id, active_len, xfer_done, irq_com, irq_qed); end
    checks++; if (dif.desc_wr_rdy_o !== 1'b1 || dif.desc_rd_vld_o !== 1'b0) begin
      failures++; $display("FAIL reset_hs got rdy=%b vld=%b want rdy=1 vld=0",
        dif.desc_wr_rdy_o, dif.desc_rd_vld_o); end
  endtask

  task automatic test_single();
    do_reset();
    chn_en = 1; msk_qed = 1; msk_com = 1;
    rand_payload(8); dif.desc_wr_vld_i = 1; tick(); dif.desc_wr_vld_i = 0;
    checks++; if (xfer_id !== 2'd0 || irq_qed !== 1'b1) begin
      failures++; $display("FAIL single_push got id=%0d qed=%b want id=0 qed=1", xfer_id, irq_qed); end
    checks++; if (dif.desc_rd_vld_o !== 1'b1 || dif.desc_xlen_o !== 16'd8 || dif.desc_rd_id_o !== 2'd0) begin
      failures++; $display("FAIL single_vld got vld=%b xlen=%0d id=%0d want vld=1 xlen=8 id=0",
        dif.desc_rd_vld_o, dif.desc_xlen_o, dif.desc_rd_id_o); end
    dif.desc_rd_rdy_i = 1; tick(); dif.desc_rd_rdy_i = 0;
    checks++; if (active_len !== 16'd8 || active_id !== 2'd0 || dif.desc_rd_vld_o !== 1'b0) begin
      failures++; $display("FAIL issue got len=%0d act=%0d vld=%b want len=8 act=0 vld=0",
        active_len, active_id, dif.desc_rd_vld_o); end
    for (int k = 1; k <= 9; k++) begin
      xfer_prog = 1; tick();
      checks++; if (active_len !== LW'((k >= 8) ? 0 : 8 - k)) begin
        failures++; $display("FAIL prog_%0d got len=%0d want %0d", k, active_len, (k >= 8) ? 0 : 8 - k); end
    end
    xfer_prog = 0; xfer_cmpl = 1; tick(); xfer_cmpl = 0;
    checks++; if (xfer_done !== 4'b0001 || irq_com !== 1'b1) begin
      failures++; $display("FAIL cmpl got done=%b com=%b want 0001 1", xfer_done, irq_com); end
    msk_qed = 0; msk_com = 0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    chn_en = 1; msk_com = 1;
    for (int k = 0; k < 4; k++) begin
      rand_payload(-1); dif.desc_wr_vld_i = 1; tick();
      checks++; if (xfer_id !== IDW'(k)) begin
        failures++; $display("FAIL fill_id_%0d got %0d want %0d", k, xfer_id, k); end
    end
    dif.desc_wr_vld_i = 0;
    checks++; if (dif.desc_wr_rdy_o !== 1'b0) begin
      failures++; $display("FAIL full_rdy got %b want 0", dif.desc_wr_rdy_o); end
    dif.desc_rd_rdy_i = 1; tick(); dif.desc_rd_rdy_i = 0;
    checks++; if (dif.desc_wr_rdy_o !== 1'b0) begin
      failures++; $display("FAIL issue_not_free got rdy=%b want 0", dif.desc_wr_rdy_o); end
    // Completion and push together while full: the push must not be taken.
    rand_payload(-1); dif.desc_wr_vld_i = 1; xfer_cmpl = 1; tick();
    dif.desc_wr_vld_i = 0; xfer_cmpl = 0;
    checks++; if (dif.desc_wr_rdy_o !== 1'b1 || xfer_done !== 4'b0001 || xfer_id !== 2'd3) begin
      failures++; $display("FAIL no_bypass got rdy=%b done=%b id=%0d want 1 0001 3",
        dif.desc_wr_rdy_o, xfer_done, xfer_id); end
    rand_payload(-1); dif.desc_wr_vld_i = 1; tick(); dif.desc_wr_vld_i = 0;
    checks++; if (xfer_id !== 2'd0 || xfer_done !== 4'b0000 || dif.desc_wr_rdy_o !== 1'b0) begin
      failures++; $display("FAIL wrap_push got id=%0d done=%b rdy=%b want 0 0000 0",
        xfer_id, xfer_done, dif.desc_wr_rdy_o); end
    msk_com = 0;
  endtask

  task automatic test_chn_en();
    do_reset();
    chn_en = 0;
    for (int k = 0; k < 2; k++) begin
      rand_payload(-1); dif.desc_wr_vld_i = 1; dif.desc_rd_rdy_i = 1; tick();
      checks++; if (dif.desc_rd_vld_o !== 1'b0 || xfer_id !== IDW'(k)) begin
        failures++; $display("FAIL chn_off_%0d got vld=%b id=%0d want 0 %0d", k, dif.desc_rd_vld_o, xfer_id, k); end
    end
    dif.desc_wr_vld_i = 0; dif.desc_rd_rdy_i = 0;
    chn_en = 1; #1;
    checks++; if (dif.desc_rd_vld_o !== 1'b1 || dif.desc_rd_id_o !== 2'd0) begin
      failures++; $display("FAIL chn_on got vld=%b id=%0d want 1 0", dif.desc_rd_vld_o, dif.desc_rd_id_o); end
    dif.desc_rd_rdy_i = 1; tick(); dif.desc_rd_rdy_i = 0;
    checks++; if (active_id !== 2'd0 || active_len !== m_q[0].xlen) begin
      failures++; $display("FAIL chn_issue got act=%0d len=%0d want 0 %0d", active_id, active_len, m_q[0].xlen); end
  endtask

  task automatic test_irq_clear();
    msk_com = 1;
    xfer_cmpl = 1; irq_clr = 2'b01; tick(); xfer_cmpl = 0; irq_clr = 2'b00;
    checks++; if (irq_com !== 1'b1) begin
      failures++; $display("FAIL set_beats_clr got com=%b want 1", irq_com); end
    irq_clr = 2'b01; tick(); irq_clr = 2'b00;
    checks++; if (irq_com !== 1'b0) begin
      failures++; $display("FAIL clr_alone got com=%b want 0", irq_com); end
    msk_com = 0;
  endtask

  task automatic test_random();
    bit vld_exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      chn_en = ($urandom_range(0, 9) != 0);
      msk_com = $urandom; msk_qed = $urandom;
      irq_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      rand_payload(-1);
      dif.desc_wr_vld_i = $urandom; dif.desc_rd_rdy_i = $urandom;
      xfer_prog = $urandom; xfer_cmpl = ($urandom_range(0, 5) == 0);
      tick();
      #1;
      vld_exp = chn_en && !m_active && (m_q.size() > 0);
      checks++; if (dif.desc_wr_rdy_o !== (m_q.size() < int'(D)) || dif.desc_rd_vld_o !== vld_exp) begin
        failures++; $display("FAIL rnd_hs n=%0d got rdy=%b vld=%b want %b %b", n, dif.desc_wr_rdy_o,
          dif.desc_rd_vld_o, m_q.size() < int'(D), vld_exp); end
      checks++; if (xfer_id !== IDW'(m_xfer_id) || xfer_done !== m_done || active_id !== IDW'(m_act_id)
                    || active_len !== LW'(m_len) || irq_com !== m_irq_com || irq_qed !== m_irq_qed) begin
        failures++; $display("FAIL rnd_regs n=%0d got id=%0d done=%b act=%0d len=%0d com=%b qed=%b want %0d %b %0d %0d %b %b",
          n, xfer_id, xfer_done, active_id, active_len, irq_com, irq_qed,
          m_xfer_id, m_done, m_act_id, m_len, m_irq_com, m_irq_qed); end
      if (vld_exp) begin
        checks++; if (dif.desc_rd_id_o !== IDW'(m_q[0].id) || dif.desc_src_addr_o !== m_q[0].src
                      || dif.desc_dst_addr_o !== m_q[0].dst || dif.desc_xlen_o !== m_q[0].xlen
                      || dif.desc_ylen_o !== m_q[0].ylen || dif.desc_src_strd_o !== m_q[0].sstr
                      || dif.desc_dst_strd_o !== m_q[0].dstr) begin
          failures++; $display("FAIL rnd_head n=%0d got id=%0d src=%h xlen=%0d want id=%0d src=%h xlen=%0d",
            n, dif.desc_rd_id_o, dif.desc_src_addr_o, dif.desc_xlen_o, m_q[0].id, m_q[0].src, m_q[0].xlen); end
      end
    end
    drive_idle();
  endtask

  task automatic test_reset_active();
    do_reset();
    chn_en = 1; msk_qed = 1;
    for (int k = 0; k < 3; k++) begin
      rand_payload(5); dif.desc_wr_vld_i = 1; tick();
    end
    dif.desc_wr_vld_i = 0; dif.desc_rd_rdy_i = 1; tick(); dif.desc_rd_rdy_i = 0;
    xfer_prog = 1; tick(); xfer_prog = 0;
    checks++; if (active_len !== 16'd4 || irq_qed !== 1'b1) begin
      failures++; $display("FAIL pre_reset got len=%0d qed=%b want 4 1", active_len, irq_qed); end
    aresetn = 0; tick();
    checks++; if ({xfer_id, active_id, active_len, xfer_done, irq_com, irq_qed} !== '0
                  || dif.desc_xlen_o !== '0 || dif.desc_rd_id_o !== '0) begin
      failures++; $display("FAIL active_reset_regs got id=%0d act=%0d len=%0d done=%b qed=%b xlen=%0d want all 0",
        xfer_id, active_id, active_len, xfer_done, irq_qed, dif.desc_xlen_o); end
    checks++; if (dif.desc_wr_rdy_o !== 1'b1 || dif.desc_rd_vld_o !== 1'b0) begin
      failures++; $display("FAIL active_reset_hs got rdy=%b vld=%b want 1 0", dif.desc_wr_rdy_o, dif.desc_rd_vld_o); end
    aresetn = 1; msk_qed = 0;
  endtask

  initial begin
    model_reset();
    rand_payload(0);
    drive_idle();
    test_reset();
    test_single();
    test_full_wrap();
    test_chn_en();
    test_irq_clear();
    test_random();
    test_reset_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end
endmodule
